prio_arbiter: RTL

//  Parametrised N-requester arbiter; generalises the 4-input fixed priority encoder.

---
 rtl/prio_arb_pkg.sv | 15 +
 rtl/prio_pick.sv | 53 +++++
 rtl/prio_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/prio_arb_pkg.sv
// Purpose : shared constants and state encoding for the prio_arbiter block.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: MODE_FIXED / MODE_RR select values, state_t FSM encoding.
package prio_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;   // highest set request index wins
   localparam logic MODE_RR    = 1'b1;   // round-robin from the rotating pointer

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/prio_pick.sv
// Purpose : combinational winner search over an N-bit request vector.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the result is valid whenever the inputs are.
// Ports   : req_i   N-bit request vector
//           start_i first index examined by the ascending search
//           dir_i   0 = descending scan from N-1, 1 = ascending scan from start_i with wrap
//           onehot_o/idx_o/found_o  winner as one-hot, binary index, and a valid flag
module prio_pick #(
   parameter int N    = 4,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] start_i,
   input  logic            dir_i,
   output logic [N-1:0]    onehot_o,
   output logic [IDXW-1:0] idx_o,
   output logic            found_o
);

   int s;
   int j;

   always_comb begin
      idx_o    = '0;
      found_o  = 1'b0;
      onehot_o = '0;
      s        = 0;
      j        = 0;
      if (!dir_i) begin
         // Ascending loop, so the highest set index is the last assignment to stick.
         for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
               idx_o   = IDXW'(i);
               found_o = 1'b1;
            end
         end
      end else begin
         // An out-of-range start (only possible when N is not a power of 2) falls back to 0.
         s = (int'(start_i) < N) ? int'(start_i) : 0;
         // Walk offsets from farthest to nearest so the nearest set bit after start wins.
         for (int k = N - 1; k >= 0; k--) begin
            j = s + k;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
               idx_o   = IDXW'(j);
               found_o = 1'b1;
            end
         end
      end
      if (found_o) onehot_o = N'(1) << idx_o;
   end

endmodule

// File: rtl/prio_arbiter.sv
// Purpose : N-requester arbiter, fixed-priority or round-robin, lock-until-release with optional RR hold timeout.
// Latency : grant registered, visible 1 cycle after the request; handover between owners has no idle bubble.
// Backpressure: requesters hold req high until served; a grant is kept while its req stays high (or until timeout).
// Ports   : clk, rst (sync active-high), req[N], mode (0 fixed / 1 round-robin),
//           gnt[N] one-hot, gnt_idx binary index (0 when idle), gnt_valid = |gnt.
module prio_arbiter
   import prio_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            mode,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_valid
);

   localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
   localparam logic [HCW-1:0] HOLD_SAT  = HCW'(MAX_HOLD);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

   state_t          state_q;
   logic [N-1:0]    gnt_q;
   logic [IDXW-1:0] gnt_idx_q;
   logic            gnt_valid_q;
   logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
   logic [HCW-1:0]  hold_cnt_q;

   logic            owner_req;
   logic            timeout;
   logic            end_grant;
   logic            arbitrate;
   logic [N-1:0]    pick_onehot;
   logic [IDXW-1:0] pick_idx;
   logic            pick_found;

   // Owner still requesting; gnt_q is one-hot so the AND-reduce avoids indexing by gnt_idx_q.
   assign owner_req = |(req & gnt_q);

   // The counter saturates at MAX_HOLD, so a grant already held past the limit in fixed mode
   // cannot time out after a switch to round-robin: the current grant is left alone.
   assign timeout   = (MAX_HOLD != 0) && (mode == MODE_RR) && (hold_cnt_q == HOLD_LAST);
   assign end_grant = (state_q == ST_GRANT) && (!owner_req || timeout);
   assign arbitrate = (state_q == ST_IDLE) || end_grant;

   // Pointer moves past the outgoing owner before the new winner is searched,
   // so a timed-out owner is only re-granted if nobody else is requesting.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (end_grant && (mode == MODE_RR)) begin
         rr_ptr_d = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
      end
   end

   prio_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req_i    (req),
      .start_i  (rr_ptr_d),
      .dir_i    (mode),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .found_o  (pick_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
         hold_cnt_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (arbitrate) begin
            hold_cnt_q <= '0;
            if (pick_found) begin
               state_q     <= ST_GRANT;
               gnt_q       <= pick_onehot;
               gnt_idx_q   <= pick_idx;
               gnt_valid_q <= 1'b1;
            end else begin
               state_q     <= ST_IDLE;
               gnt_q       <= '0;
               gnt_idx_q   <= '0;
               gnt_valid_q <= 1'b0;
            end
         end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
         end
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule
